// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer: one digit pair per clock through a
// binary add plus +6 decimal adjust, with the decimal carry held between digits.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   a_reg, b_reg, res_reg, res_next, sum_reg;
  logic [CW-1:0]  cnt_reg;
  logic           carry_reg, err_acc_reg, cout_reg, err_reg;

  logic [3:0]     a_d, b_d, digit;
  logic [4:0]     s, s_adj;
  logic           carry_next, digit_bad, last_digit;

  // Shared digit slice: operands are consumed from the LS end of the shift regs.
  always_comb begin
    a_d        = a_reg[3:0];
    b_d        = b_reg[3:0];
    s          = {1'b0, a_d} + {1'b0, b_d} + {4'd0, carry_reg};
    s_adj      = s + 5'd6;
    carry_next = (s > 5'd9);
    digit      = carry_next ? s_adj[3:0] : s[3:0];
    digit_bad  = (a_d > 4'd9) | (b_d > 4'd9);
    last_digit = (cnt_reg == CW'(DIGITS - 1));
  end

  // Result digits enter at the MS end so digit 0 lands in [3:0] after DIGITS shifts.
  generate
    if (DIGITS == 1) begin : g_res_single
      assign res_next = digit;
    end else begin : g_res_multi
      assign res_next = {digit, res_reg[W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      res_reg     <= '0;
      sum_reg     <= '0;
      cnt_reg     <= '0;
      carry_reg   <= 1'b0;
      err_acc_reg <= 1'b0;
      cout_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg       <= a;
            b_reg       <= b;
            carry_reg   <= cin;
            cnt_reg     <= '0;
            err_acc_reg <= 1'b0;
          end
        end
        CALC: begin
          a_reg       <= a_reg >> 4;
          b_reg       <= b_reg >> 4;
          res_reg     <= res_next;
          carry_reg   <= carry_next;
          cnt_reg     <= cnt_reg + CW'(1);
          err_acc_reg <= err_acc_reg | digit_bad;
          // Visible outputs change only here, never with partial results.
          if (last_digit) begin
            sum_reg  <= res_next;
            cout_reg <= carry_next;
            err_reg  <= err_acc_reg | digit_bad;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: directed cases plus randomized
// operands checked against a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Valid operands: true decimal addition. Invalid digits: per-digit rule.
  function automatic void ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                  input logic rc, output logic [W-1:0] rs,
                                  output logic rco, output logic rerr);
    bit     bad;
    longint va, vb, lim, tot;
    int     c, s;
    bad = 0;
    rs  = '0;
    for (int i = 0; i < DIGITS; i++)
      if (ra[4*i +: 4] > 9 || rb[4*i +: 4] > 9) bad = 1;
    rerr = bad;
    if (!bad) begin
      va = 0; vb = 0; lim = 1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        va  = va * 10 + longint'(ra[4*i +: 4]);
        vb  = vb * 10 + longint'(rb[4*i +: 4]);
        lim = lim * 10;
      end
      tot = va + vb + longint'(rc);
      rco = (tot >= lim);
      if (rco) tot = tot - lim;
      for (int i = 0; i < DIGITS; i++) begin
        rs[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      c = int'(rc);
      for (int i = 0; i < DIGITS; i++) begin
        s = int'(ra[4*i +: 4]) + int'(rb[4*i +: 4]) + c;
        if (s > 9) begin
          rs[4*i +: 4] = 4'((s + 6) % 16);
          c = 1;
        end else begin
          rs[4*i +: 4] = 4'(s);
          c = 0;
        end
      end
      rco = c[0];
    end
  endfunction

  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] oa,
                        input logic [W-1:0] ob, input logic oc);
    logic [W-1:0] es;
    logic         eco, eerr;
    int           busy_cnt, cyc;
    ref_add(oa, ob, oc, es, eco, eerr);
    start = 1'b1; a = oa; b = ob; cin = oc;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    busy_cnt = 0; cyc = 0;
    while (!done && cyc < DIGITS + 10) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    $display("op %s a=%h b=%h cin=%0d -> sum=%h cout=%0d err=%0d (model %h/%0d/%0d)",
             tag, oa, ob, oc, sum, cout, err, es, eco, eerr);
    check({tag, ".latency"}, 64'(cyc), 64'(DIGITS));
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(DIGITS));
    check({tag, ".busy_in_done"}, 64'(busy), 64'(0));
    check({tag, ".sum"}, 64'(sum), 64'(es));
    check({tag, ".cout"}, 64'(cout), 64'(eco));
    check({tag, ".err"}, 64'(err), 64'(eerr));
    @(posedge clk); #1;
    check({tag, ".done_one_cycle"}, 64'(done), 64'(0));
  endtask

  initial begin
    int dones;
    logic [W-1:0] ra, rb;
    bit bad;

    @(posedge clk); #1;
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.done", 64'(done), 64'(0));
    check("reset.sum", 64'(sum), 64'(0));
    check("reset.cout", 64'(cout), 64'(0));
    check("reset.err", 64'(err), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("d1234", 16'h1234, 16'h4321, 1'b0);
    check("d1234.const_sum", 64'(sum), 64'h5555);
    run_op("d9999", 16'h9999, 16'h0001, 1'b0);
    check("d9999.const_sum", 64'(sum), 64'h0000);
    check("d9999.const_cout", 64'(cout), 64'(1));
    run_op("d0958", 16'h0958, 16'h0047, 1'b1);
    check("d0958.const_sum", 64'(sum), 64'h1006);

    // start held through CALC with changing operands: one result only
    start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(posedge clk); #1;
    a = 16'h5555;
    dones = 0;
    for (int i = 0; i < DIGITS + 4; i++) begin
      if (done) begin
        dones++;
        check("hold.sum", 64'(sum), 64'h3333);
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    $display("op hold a=1111 b=2222 -> done pulses=%0d sum=%h", dones, sum);
    check("hold.done_pulses", 64'(dones), 64'(1));
    check("hold.idle_busy", 64'(busy), 64'(0));

    // reset in the middle of an operation
    start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst.busy", 64'(busy), 64'(0));
    check("midrst.done", 64'(done), 64'(0));
    check("midrst.sum", 64'(sum), 64'(0));
    check("midrst.cout", 64'(cout), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < DIGITS + 3; i++) begin
      if (done || busy) dones++;
      @(posedge clk); #1;
    end
    $display("op midrst a=1234 b=4321 -> aborted, activity cycles=%0d", dones);
    check("midrst.no_activity", 64'(dones), 64'(0));
    run_op("after_rst", 16'h0001, 16'h0002, 1'b0);
    check("after_rst.const_sum", 64'(sum), 64'h0003);

    run_op("inval", 16'h00A0, 16'h0000, 1'b0);
    check("inval.const_sum", 64'(sum), 64'h0100);
    check("inval.const_err", 64'(err), 64'(1));
    run_op("post_inval", 16'h0001, 16'h0001, 1'b0);
    check("post_inval.const_err", 64'(err), 64'(0));

    for (int n = 0; n < 24; n++) begin
      bad = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = bad ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        rb[4*i +: 4] = bad ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      end
      run_op($sformatf("rnd%0d", n), ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
- Sequencer for a digit-serial packed-BCD adder.
- Each cycle, one 4-bit digit pair goes through a binary add followed by the +6 decimal-adjust correction.
- The ripple decimal carry is kept in a register between digits, so one digit slice is time-shared across all digits of the operand.
- Sits between a requesting unit (start/done handshake) and the BCD result consumer.

Parameters:
- DIGITS, 4, number of BCD digits per operand (min 1, max 16).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset: asynchronous and active-high.
- start, input, 1, request; sampled only in IDLE.
- a, input, 4*DIGITS, BCD operand A, digit 0 in bits [3:0]; sampled with start.
- b, input, 4*DIGITS, BCD operand B, same packing; sampled with start.
- cin, input, 1, decimal carry-in; sampled with start.
- busy, output, 1, high while an operation is in progress (CALC state).
- done, output, 1, one-cycle pulse when sum/cout/err are valid and updated.
- sum, output, 4*DIGITS, BCD result, same packing as a.
- cout, output, 1, decimal carry-out of the most significant digit.
- err, output, 1, high if any input digit of the last operation was >9.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, cout=0, err=0; internal operand regs, carry and counter cleared. Effective immediately, including mid-operation; the in-flight operation is discarded.
- FSM states: IDLE, CALC, DONE.
- IDLE -> CALC: on a clock edge with start=1.
  - Latch a, b into operand shift registers; carry<=cin; cnt<=0; err_acc<=0.
  - busy=1 from the next cycle.
- CALC: each edge processes digit cnt.
  - Form s = a_d + b_d + carry, 5 bits.
  - If s>9: digit = (s+6)[3:0] and carry<=1.
  - Else: digit = s[3:0] and carry<=0.
  - Shift the digit into the internal result register from the MS end, shift both operand regs down 4 bits, cnt<=cnt+1.
  - err_acc |= (a_d>9)|(b_d>9).
  - The edge with cnt==DIGITS-1 moves to DONE.
- CALC -> DONE: on that final edge, registered together with the state change:
  - sum<=full result; cout<=final carry; err<=err_acc|this digit's check.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE unconditionally.
- Latency: start sampled at edge k; done high during the cycle after edge k+DIGITS; next start accepted at edge k+DIGITS+2 or later.
- start while in CALC or DONE: ignored, not queued. a/b/cin changes after the start edge have no effect.
- sum, cout and err hold their last values in IDLE and CALC. They update only on entry to DONE, never with partial results.
- Invalid digits (>9) are processed by the same rule (deterministic result) and flagged via err.
- Max per-digit s = 9+9+1 = 19. Invalid digits give up to 31 and still fit in 5 bits; the (s+6)[3:0] wrap is intentional.
- cnt width is $clog2(DIGITS)+1 bits. No wrap-around within an operation.

Test Plan:
- Reset, then a=1234, b=4321, cin=0, start one cycle -> busy high 4 cycles; done pulse in the 5th cycle after the start edge with sum=5555, cout=0, err=0.
- a=9999, b=0001, cin=0 -> sum=0000, cout=1; carry ripples through all 4 digits.
- a=0958, b=0047, cin=1 -> sum=1006, cout=0. Checks the digit-0 (8+7+1=16 -> 6, carry 1) and digit-1 adjust paths.
- Start a=1111, b=2222; hold start high and apply a=5555 during CALC -> exactly one done pulse, sum=3333. A second op is accepted only after return to IDLE.
- Start a=1234, b=4321, assert rst for one cycle after the 2nd digit edge -> busy=0, done never pulses, sum=0000, cout=0. A subsequent start of a=0001, b=0002 gives sum=0003.
- a=00A0, b=0000, cin=0 -> sum=0100, cout=0, err=1. Next op 0001+0001 -> sum=0002, err=0.
